// File: rtl/transmitting_pkg.sv
// Shared constants and FSM encoding for the serial transmitter/receiver pair.
// Keeping these in one package prevents the two ends from drifting apart.
package transmitting_pkg;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 7;
    localparam int FRAME_BITS   = 1 + DATA_BITS + 1 + 1;
    localparam int BIT_IDX_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/transmitting_bit_timer.sv
// Bit-period divider: counts 0..CLKS-1 and pulses tick on the last count.
// Held at zero while clear is high so a new frame always starts on a full bit.
module bit_timer #(
    parameter int CLKS = 16,
    localparam int CNT_W = (CLKS > 1) ? $clog2(CLKS) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/transmitting.sv
// Serial frame transmitter: start(0), 7 data bits LSB first, even parity, stop(1).
// All outputs come straight from flops; the next-value logic looks one state ahead.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | line high, waiting for load
//   ST_START  | start bit (line low) for one bit period
//   ST_DATA   | data bit[bit_idx], LSB first
//   ST_PARITY | even-parity bit
//   ST_STOP   | stop bit (line high); exits to IDLE with charSent
module transmitting
    import transmitting_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 data_out,
    output logic                 busy,
    output logic                 charSent
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_e              state;
    tx_state_e              state_nxt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   parity;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BIT_IDX_W-1:0]   bit_idx_nxt;
    logic                   tick;
    logic                   accept;
    logic                   data_out_nxt;
    logic                   busy_nxt;
    logic                   char_sent_nxt;

    assign accept = (state == ST_IDLE) && load;

    bit_timer #(
        .CLKS (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (reset),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load) state_nxt = ST_START;
            ST_START:  if (tick) state_nxt = ST_DATA;
            ST_DATA:   if (tick && (bit_idx == LAST_IDX)) state_nxt = ST_PARITY;
            ST_PARITY: if (tick) state_nxt = ST_STOP;
            ST_STOP:   if (tick) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_idx_nxt = '0;
        if (state == ST_DATA) begin
            bit_idx_nxt = tick ? (bit_idx + BIT_IDX_W'(1)) : bit_idx;
        end
    end

    // Character and parity are latched once at accept; data_in is ignored afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            parity  <= 1'b0;
            bit_idx <= '0;
        end else begin
            bit_idx <= bit_idx_nxt;
            if (accept) begin
                shreg  <= data_in;
                parity <= even_parity(data_in);
            end
        end
    end

    always_comb begin
        data_out_nxt  = 1'b1;
        busy_nxt      = (state_nxt != ST_IDLE);
        char_sent_nxt = (state == ST_STOP) && (state_nxt == ST_IDLE);
        case (state_nxt)
            ST_IDLE:   data_out_nxt = 1'b1;
            ST_START:  data_out_nxt = 1'b0;
            ST_DATA:   data_out_nxt = shreg[bit_idx_nxt];
            ST_PARITY: data_out_nxt = parity;
            ST_STOP:   data_out_nxt = 1'b1;
            default:   data_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 1'b1;
            busy     <= 1'b0;
            charSent <= 1'b0;
        end else begin
            data_out <= data_out_nxt;
            busy     <= busy_nxt;
            charSent <= char_sent_nxt;
        end
    end

endmodule

// File: doc/transmitting.md
Name: transmitting

Overview:
- Serial frame transmitter that drives the line read by the existing `receiving` block.
- Frame format: 1 start bit (0), 7 data bits sent LSB first, 1 even-parity bit, 1 stop bit (1). That is 10 bits per frame.
- Each bit is held for CLKS_PER_BIT clocks of `clk`, which matches the receiver's 16x oversampling.
- Sits between the processor's output register and the serial line. It accepts one character per `load` pulse.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; legal range is 2 or more.
- DATA_BITS, 7, payload width.
- FRAME_BITS, 10, total bits per frame: start + DATA_BITS + parity + stop.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  request to send `data_in`; sampled on rising `clk`.
- data_in  input  DATA_BITS  character to transmit; captured when `load` is accepted.
- data_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- charSent  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: one clock (`clk`); reset is asynchronous and active-low.
  - While reset is low: `data_out`=1, `busy`=0, `charSent`=0, FSM=IDLE, bit counter=0, clock counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame. The line returns high asynchronously and no `charSent` pulse is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `data_out`=1, `busy`=0.
  - On a rising edge with `load`=1: capture `data_in` into the shift register, compute parity = XOR of the captured bits, go to START, clear the clock counter.
  - `load`=0 keeps the FSM in IDLE.
- START: `data_out`=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - `data_out` = shift register bit[index], LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After index DATA_BITS-1 completes, go to PARITY.
- PARITY: `data_out` = computed parity for CLKS_PER_BIT cycles. The parity makes the total count of ones in data+parity even.
- STOP:
  - `data_out`=1 for CLKS_PER_BIT cycles.
  - On the final cycle, transition to IDLE and assert `charSent` for exactly one cycle; this is the first IDLE cycle.
- Timing:
  - Latency: `data_out` falls on the first rising edge after `load` is sampled.
  - `busy` rises on that same edge and stays high for FRAME_BITS*CLKS_PER_BIT = 160 cycles.
- Outputs are registered; no combinational path from `load` to `data_out`.
- Boundary conditions:
  - `load` while `busy`=1 is ignored. It is neither queued nor corrupting, and `data_in` changes mid-frame have no effect.
  - `load` held high continuously: frames go out back-to-back with exactly one idle-high cycle between them, so the stop bit is effectively CLKS_PER_BIT+1 cycles.
  - `load` during the `charSent` cycle is accepted, because that cycle is IDLE.
- Counter widths: the clock counter is ceil(log2(CLKS_PER_BIT)) bits and wraps to 0 at CLKS_PER_BIT-1; the bit index is 3 bits.

Decomposition:
- Shared package:
  - Constants CLKS_PER_BIT, DATA_BITS and FRAME_BITS.
  - The FSM state encoding.
  - Shared so that `receiving` and `transmitting` stay consistent.
- Sub-module `bit_timer`:
  - Clock-divide counter with a `clear` input and a `tick` output (asserted on count CLKS_PER_BIT-1).
  - Reusable by the receiver.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles with `load`=1 → `data_out`=1, `busy`=0, `charSent`=0 throughout; no frame starts until after reset is released.
- Nominal frame: `load` pulse with `data_in`=7'h4B.
  - Line must show, per 16-cycle bit: 0,1,1,0,1,0,0,1,0,1 (parity 0).
  - `busy` high for 160 cycles; `charSent` pulses once, at cycle 161 after `load`.
- Odd parity data: `data_in`=7'h01 → bits 0,1,0,0,0,0,0,0,1,1 (parity 1).
  - Loop `data_out` back into the `receiving` block, which must report the frame without error.
- Ignored load: a second `load` with 7'h7F at cycle 40 of a frame carrying 7'h4B → the frame is unchanged and no second frame follows.
- Back-to-back: `load` held high with `data_in`=7'h55 → consecutive frames, each starting exactly 1 idle-high cycle after the previous stop bit. `charSent` pulses every 161 cycles.
- Reset mid-frame: assert `reset` during the DATA state → `data_out`=1 immediately, with no clock edge needed. No `charSent` pulse. A new `load` after release produces a full correct frame.
